// File: rtl/cla_multicycle_add_ctrl_if.sv
// Purpose: groups the operand-request and result handshakes of the
//          multicycle CLA adder into one bundle.
// Signals:
//   in_valid/in_ready    operand handshake (producer -> adder)
//   a, b, c_in           operands and carry into bit 0
//   out_valid/out_ready  result handshake (adder -> consumer)
//   sum, c_out, ovf,     result word, carry out, signed overflow,
//   zero, busy           zero flag, adder-not-idle
// Modports: master = producer/consumer side, slave = adder side.
interface cla_multicycle_add_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, zero, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, zero, busy
  );
endinterface

// File: rtl/cla_multicycle_add_ctrl.sv
// Purpose: WIDTH-bit adder that reuses one 4-bit carry-lookahead slice,
//          one nibble per cycle, LSB nibble first. The slice carry-out is
//          registered as the next nibble's carry-in.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; discards any in-flight add
//   bus   slave side of cla_multicycle_add_ctrl_if (operand request,
//         result + flags, busy)
module cla_multicycle_add_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  cla_multicycle_add_ctrl_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned MSB    = WIDTH - 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_width_check
    $fatal(1, "cla_multicycle_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  // Slice datapath signals
  logic [IDX_W+1:0] bit_sh;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [3:0]       sl_a, sl_b, sl_g, sl_p, sl_s;
  logic [4:0]       sl_c;
  logic [WIDTH-1:0] sum_nx;

  // Select the current nibble, run the 4-bit CLA, merge its sum into sum_q
  always_comb begin
    bit_sh = {idx_q, 2'b00};
    a_sh   = op_a_q >> bit_sh;
    b_sh   = op_b_q >> bit_sh;
    sl_a   = a_sh[3:0];
    sl_b   = b_sh[3:0];
    sl_g   = sl_a & sl_b;
    sl_p   = sl_a ^ sl_b;
    sl_c[0] = carry_q;
    sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
    sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_s   = sl_p ^ sl_c[3:0];
    sum_nx = (sum_q & ~(WIDTH'(4'hF) << bit_sh)) | (WIDTH'(sl_s) << bit_sh);
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_a_d  = bus.a;
          op_b_d  = bus.b;
          carry_d = bus.c_in;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = sum_nx;
        carry_d = sl_c[4];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_DONE;
          c_out_d = sl_c[4];
          ovf_d   = (op_a_q[MSB] == op_b_q[MSB]) && (sum_nx[MSB] != op_a_q[MSB]);
          zero_d  = (sum_nx == '0);
        end
      end
      ST_DONE: begin
        // Flags drop with out_valid; sum keeps its last value
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          c_out_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake/status outputs are registered copies of the next state
    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy_q;

endmodule
